// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit (master) and the
// datapath (slave): instruction fields and flags in, mux selects and strobes out.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, InstrDone, IllegalOp, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, InstrDone, IllegalOp, State
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request and the R-type funct field to the
// 3-bit ALU operation code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALUC_ADD;
          FN_SUB:  alu_control = ALUC_SUB;
          FN_AND:  alu_control = ALUC_AND;
          FN_OR:   alu_control = ALUC_OR;
          FN_SLT:  alu_control = ALUC_SLT;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath; every
// output is decoded from the current state and forced low during reset.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  state_t     state;
  state_t     state_next;
  alu_op_t    alu_op;
  logic [2:0] alu_ctrl;
  logic       pc_write;
  logic       branch;
  logic       active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (alu_ctrl)
  );

  // Outputs stay at zero while reset is held and in the unused codes 12-15.
  always_comb begin
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_B;
    bus.PCSrc     = PCSRC_ALU;
    bus.InstrDone = 1'b0;
    bus.IllegalOp = 1'b0;
    alu_op        = ALUOP_ADD;
    pc_write      = 1'b0;
    branch        = 1'b0;
    active        = 1'b0;
    if (!reset) begin
      active = 1'b1;
      case (state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = 1'b1;
          pc_write    = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
        end
        S_DECODE: begin
          bus.ALUSrcB   = SRCB_IMM_SH;
          bus.IllegalOp = !op_supported(bus.Opcode);
          bus.InstrDone = !op_supported(bus.Opcode);
        end
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        S_MEMWB: begin
          bus.MemtoReg  = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD      = 1'b1;
          bus.MemWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_EXECUTE: begin
          bus.ALUSrcA = 1'b1;
          alu_op      = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          bus.RegDst    = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA   = 1'b1;
          alu_op        = ALUOP_SUB;
          bus.PCSrc     = PCSRC_ALUOUT;
          branch        = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: begin
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_JUMP: begin
          bus.PCSrc     = PCSRC_JUMP;
          pc_write      = 1'b1;
          bus.InstrDone = 1'b1;
        end
        default: active = 1'b0;
      endcase
    end
    bus.PCEn       = pc_write | (branch & bus.Zero);
    bus.ALUControl = active ? alu_ctrl : 3'b000;
  end

  assign bus.State = state;

endmodule
